// File: rtl/sd_crc16_unit.sv
// sd_crc16_unit
// CRC-16/XMODEM (poly 0x1021, MSB-first, no reflection, no final XOR) engine
// that sits beside an SPI shifter for SD-card block transfers. It hashes one
// bit per bit_stb, taken from either mosi or miso. With chk_en set it frames
// one data block of BLOCK_BYTES bytes. It then captures the 16 CRC bits that
// follow the block and compares them against the hash of the data.
//
// Ports
//   cck       clock, rising edge
//   _reset    synchronous active-low reset
//   clr       one-cycle clear of CRC, counters, FSM and flags (wins over bit_stb)
//   src_sel   0 = hash mosi, 1 = hash miso
//   chk_en    1 = block framing + CRC check, 0 = free-running CRC
//   bit_stb   one-cycle strobe marking a valid serial bit
//   mosi      outgoing serial bit
//   miso      incoming serial bit
//   crc       running CRC register
//   byte_cnt  completed bytes since clear (mod 1024)
//   busy      FSM in DATA or CHECK
//   crc_ok    sticky: received CRC matched
//   crc_err   sticky: received CRC mismatched
//
// state | meaning
// IDLE  | cleared, waiting for the first bit
// DATA  | hashing data bits
// CHECK | shifting received CRC into rx_crc, crc frozen
// DONE  | verdict latched, all bits ignored until clr/reset

module sd_crc16_unit #(
    parameter int          BLOCK_BYTES = 512,
    parameter logic [15:0] INIT        = 16'h0000
) (
    input  logic        cck,
    input  logic        _reset,
    input  logic        clr,
    input  logic        src_sel,
    input  logic        chk_en,
    input  logic        bit_stb,
    input  logic        mosi,
    input  logic        miso,
    output logic [15:0] crc,
    output logic [9:0]  byte_cnt,
    output logic        busy,
    output logic        crc_ok,
    output logic        crc_err
);

    typedef enum logic [1:0] {IDLE, DATA, CHECK, DONE} state_t;

    localparam logic [9:0] LAST_BYTE = 10'(BLOCK_BYTES - 1);

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [3:0]  rx_cnt;
    logic [15:0] rx_crc;
    logic [15:0] crc_snap;

    logic        bit_in;
    logic [15:0] crc_next;
    logic [15:0] rx_next;
    logic        byte_done;

    assign bit_in    = src_sel ? miso : mosi;
    assign crc_next  = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? 16'h1021 : 16'h0000);
    assign rx_next   = {rx_crc[14:0], bit_in};
    assign byte_done = (bit_cnt == 3'd7);

    always_ff @(posedge cck) begin
        if (!_reset || clr) begin
            state    <= IDLE;
            crc      <= INIT;
            bit_cnt  <= 3'd0;
            byte_cnt <= 10'd0;
            rx_cnt   <= 4'd0;
            rx_crc   <= 16'h0000;
            crc_snap <= INIT;
            busy     <= 1'b0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
        end else if (bit_stb) begin
            case (state)
                IDLE, DATA: begin
                    crc     <= crc_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    state   <= DATA;
                    busy    <= 1'b1;
                    if (byte_done) begin
                        byte_cnt <= byte_cnt + 10'd1;
                    end
                    // The bit closing the last data byte ends the block; the
                    // snapshot holds the post-update CRC for the comparison.
                    if (chk_en && byte_done && byte_cnt == LAST_BYTE) begin
                        state    <= CHECK;
                        crc_snap <= crc_next;
                        rx_cnt   <= 4'd0;
                    end
                end
                CHECK: begin
                    rx_crc  <= rx_next;
                    rx_cnt  <= rx_cnt + 4'd1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_done) begin
                        byte_cnt <= byte_cnt + 10'd1;
                    end
                    if (rx_cnt == 4'd15) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        if (rx_next == crc_snap) begin
                            crc_ok <= 1'b1;
                        end else begin
                            crc_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sd_crc16_unit.md
SD_CRC16_UNIT -- requirements
Module: sd_crc16_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- BLOCK_BYTES, 512, data bytes per SD block before the CRC field.
- INIT, 16'h0000, CRC preset value.
REQ-002 Ports SHALL be, one per line:
- cck  input  1  sole clock; all state updates on its rising edge.
- _reset  input  1  reset; synchronous, active-low.
- clr  input  1  one-cycle pulse: reset CRC, counters, FSM and flags.
- src_sel  input  1  0 = hash mosi bit, 1 = hash miso bit.
- chk_en  input  1  1 = enforce block framing and CRC check; 0 = free-running CRC.
- bit_stb  input  1  one-cycle strobe: a bit is valid this cycle, aligned to the SPI shifter's sclk sample edge.
- mosi  input  1  outgoing serial bit from the SPI shifter.
- miso  input  1  incoming serial bit from the card.
- crc  output  16  running CRC register.
- byte_cnt  output  10  completed bytes since clear.
- busy  output  1  FSM in DATA or CHECK with at least one bit consumed.
- crc_ok  output  1  sticky: received CRC matched.
- crc_err  output  1  sticky: received CRC mismatched.

Function
REQ-003 The CRC polynomial SHALL be x^16+x^12+x^5+1 (0x1021), MSB-first, non-reflected, with no final XOR.
REQ-004 On each accepted bit b, with fb = crc[15]^b, crc SHALL become {crc[14:0],0} ^ (fb ? 0x1021 : 0); the new value is visible the cycle after bit_stb.
REQ-005 The selected bit SHALL be mosi when src_sel=0 and miso when src_sel=1, sampled in the bit_stb cycle.
REQ-006 A 3-bit bit counter SHALL count accepted bits; on wrap 7->0, byte_cnt SHALL increment by 1 modulo 1024.
REQ-007 FSM states SHALL be IDLE, DATA, CHECK and DONE.
- IDLE: first accepted bit moves the FSM to DATA and is hashed.
- DATA: bits are hashed.
- If chk_en=1, the bit completing byte BLOCK_BYTES SHALL move the FSM to CHECK, copying the post-update crc to an internal crc_snap.
- If chk_en=0, the FSM SHALL remain in DATA indefinitely.
REQ-008 In CHECK, accepted bits SHALL shift MSB-first into a 16-bit rx_crc and SHALL NOT alter crc.
- byte_cnt SHALL still count.
- After the 16th bit, the FSM SHALL go to DONE and set crc_ok if rx_crc==crc_snap, else crc_err.
- The flag SHALL be visible the cycle after that bit_stb.
REQ-009 In DONE, bit_stb SHALL be ignored: crc, byte_cnt and flags frozen until clr or reset.
REQ-010 crc_ok and crc_err SHALL never both be 1.
REQ-011 clr SHALL set crc=INIT, bit counter=0, byte_cnt=0, crc_ok=0, crc_err=0, FSM=IDLE.
REQ-012 clr and bit_stb in the same cycle: clr SHALL win and the bit SHALL be discarded.
REQ-013 Changes to src_sel or chk_en mid-byte SHALL take effect on the next accepted bit; no state is lost.
REQ-014 chk_en deasserted while in CHECK SHALL NOT abort the check.
REQ-015 busy SHALL be 1 in DATA and CHECK and 0 in IDLE and DONE.
REQ-016 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-017 When _reset=0 at a cck edge, the block SHALL apply the REQ-011 values and busy=0, overriding clr and bit_stb.
REQ-018 _reset asserted mid-byte or mid-CHECK SHALL discard partial bytes and rx_crc; the next accepted bit after release starts a new byte in IDLE->DATA.

Verification
REQ-019 clr, src_sel=0, chk_en=0, ASCII "123456789" on mosi -> crc=16'h31C3, byte_cnt=9.
REQ-020 clr, chk_en=0, 512 bytes of 0xFF on mosi -> crc=16'h7FA1, byte_cnt=512, busy=1.
REQ-021 clr, chk_en=1, src_sel=1, 512 x 0xFF then 0x7F,0xA1 on miso -> crc_ok=1, crc_err=0, crc=16'h7FA1, byte_cnt=514, busy=0; 8 more bits -> all outputs unchanged.
REQ-022 As REQ-021 but trailing bytes 0x7F,0xA0 -> crc_err=1, crc_ok=0.
REQ-023 clr asserted with bit_stb after 3 bytes -> crc=0, byte_cnt=0, IDLE; "123456789" then -> crc=16'h31C3.
REQ-024 _reset low for one cycle after 4 bits of a byte -> all outputs 0; single byte 0x00 -> crc=0, byte_cnt=1.
